// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch slice.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   BUF_DEPTH        : instruction buffer depth (only 2 supported)
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : one buffered instruction with its address
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          BUF_DEPTH        = 2;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        FULL       = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO between instruction memory and decode.
//   clk, rst_n : clock, async active-low reset
//   push       : write wr_entry at the tail
//   wr_entry   : entry to write
//   pop        : remove the head entry (ignored when empty)
//   flush      : drop all entries; has priority over push/pop
//   rd_entry   : head entry (registered)
//   count      : occupancy 0..2
//   valid      : head entry present
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t wr_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t rd_entry,
    output logic [1:0]   count,
    output logic         valid
);

    fetch_entry_t e0;
    fetch_entry_t e1;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    // A push into a full buffer is only accepted together with a pop.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= wr_entry;
                    else               e1 <= wr_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= wr_entry;
                    end else begin
                        e0 <= e1;
                        e1 <= wr_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_entry = e0;
    assign valid    = (count != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a 2-entry buffer and redirect.
//   clk, rst_n       : clock, async active-low reset
//   imem_req/addr    : fetch request and word-aligned address
//   imem_rdata       : instruction word, valid the cycle after imem_req
//   redirect_valid/pc: branch/jump redirect from execute
//   instr_valid/ready: handshake toward decode
//   instr, instr_pc, instr_pcplus4 : delivered instruction and addresses
//
// state      | meaning
// RESET_HOLD | first cycle after reset release, no request
// RUN        | requesting while buffer + in-flight credit allows
// FULL       | buffer + in-flight = depth, request only on a pop
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = fetch_pkg::BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4
);

    localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc_q;
    logic         inflight_q;
    logic [1:0]   count;
    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;
    logic         pop;
    logic         pop_eff;
    logic         push;
    logic [2:0]   occ;
    logic [2:0]   cnt_next;
    logic [2:0]   occ_next;
    logic [31:0]  addr_sel;

    always_comb begin
        pop      = instr_valid & instr_ready;
        // On a redirect the pop is void and the arriving response is stale.
        pop_eff  = pop & ~redirect_valid;
        push     = inflight_q & ~redirect_valid;
        occ      = {1'b0, count} + {2'b0, inflight_q};
        imem_req = redirect_valid |
                   ((state != RESET_HOLD) && (occ < (CREDITS + {2'b0, pop}))); 
        addr_sel = redirect_valid ? redirect_pc : fetch_pc;
        imem_addr = {addr_sel[31:2], 2'b00};
        cnt_next = redirect_valid ? 3'd0
                                  : ({1'b0, count} + {2'b0, push} - {2'b0, pop_eff});
        occ_next = cnt_next + {2'b0, imem_req};
        wr_entry = '{instr: imem_rdata, pc: req_pc_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_HOLD;
            fetch_pc   <= {RESET_PC[31:2], 2'b00};
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                req_pc_q <= imem_addr;
                fetch_pc <= imem_addr + 32'd4;
            end
            if (redirect_valid) begin
                state <= RUN;
            end else begin
                case (state)
                    RESET_HOLD: state <= RUN;
                    RUN, FULL:  state <= (occ_next == CREDITS) ? FULL : RUN;
                    default:    state <= RUN;
                endcase
            end
        end
    end

    fetch_buffer u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop_eff),
        .flush    (redirect_valid),
        .rd_entry (rd_entry),
        .count    (count),
        .valid    (instr_valid)
    );

    assign instr         = rd_entry.instr;
    assign instr_pc      = rd_entry.pc;
    assign instr_pcplus4 = rd_entry.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory: word at addr is addr + 0x100, one cycle latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr + 32'h100;
    end

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pcplus4  (instr_pcplus4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply reset, release it just after an edge; returns in the hold cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) step();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("hold_req", {31'b0, imem_req}, 32'd0);
    endtask

    initial begin
        // Startup and streaming
        instr_ready = 1'b1;
        do_reset();
        step();   // C1
        chk("c1_req", {31'b0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        step();   // C2
        chk("c2_addr", imem_addr, 32'h4);
        chk("c2_valid", {31'b0, instr_valid}, 32'd0);
        step();   // C3
        chk("c3_addr", imem_addr, 32'h8);
        chk("c3_valid", {31'b0, instr_valid}, 32'd1);
        chk("c3_pc", instr_pc, 32'h0);
        chk("c3_instr", instr, 32'h100);
        chk("c3_pc4", instr_pcplus4, 32'h4);
        step();   // C4
        chk("c4_pc", instr_pc, 32'h4);
        chk("c4_instr", instr, 32'h104);
        chk("c4_addr", imem_addr, 32'hC);

        // Back-pressure
        instr_ready = 1'b0;
        do_reset();
        step();   // C1
        chk("bp_c1_addr", imem_addr, 32'h0);
        step();   // C2
        chk("bp_c2_req", {31'b0, imem_req}, 32'd1);
        chk("bp_c2_addr", imem_addr, 32'h4);
        for (int i = 3; i <= 5; i++) begin
            step();
            chk($sformatf("bp_c%0d_req", i), {31'b0, imem_req}, 32'd0);
        end
        chk("bp_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        #1;
        chk("bp_c5_req_pop", {31'b0, imem_req}, 32'd1);
        chk("bp_c5_addr", imem_addr, 32'h8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_seq%0d_valid", i), {31'b0, instr_valid}, 32'd1);
            chk($sformatf("bp_seq%0d_pc", i), instr_pc, 32'(i * 4));
            step();
        end

        // Redirect while full
        instr_ready = 1'b0;
        do_reset();
        repeat (4) step();
        chk("rf_full_valid", {31'b0, instr_valid}, 32'd1);
        chk("rf_full_req", {31'b0, imem_req}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        chk("rf_req", {31'b0, imem_req}, 32'd1);
        chk("rf_addr", imem_addr, 32'h200);
        step();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        #1;
        chk("rf_flushed", {31'b0, instr_valid}, 32'd0);
        chk("rf_next_addr", imem_addr, 32'h204);
        step();
        chk("rf_pc", instr_pc, 32'h200);
        chk("rf_instr", instr, 32'h300);
        step();
        chk("rf_pc2", instr_pc, 32'h204);

        // Back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("rr_addr1", imem_addr, 32'h40);
        step();
        redirect_pc = 32'h80;
        #1;
        chk("rr_addr2", imem_addr, 32'h80);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rr_flushed", {31'b0, instr_valid}, 32'd0);
        chk("rr_next_addr", imem_addr, 32'h84);
        step();
        chk("rr_valid", {31'b0, instr_valid}, 32'd1);
        chk("rr_pc", instr_pc, 32'h80);
        step();
        chk("rr_pc2", instr_pc, 32'h84);

        // Redirect to the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wr_next_addr", imem_addr, 32'h0);
        step();
        chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", instr_pcplus4, 32'h0);
        chk("wr_instr", instr, 32'h0000_00FC);
        step();
        chk("wr_pc_after", instr_pc, 32'h0);

        // Reset with a full buffer
        instr_ready = 1'b0;
        repeat (4) step();
        chk("ar_full_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, instr_valid}, 32'd0);
        chk("ar_req", {31'b0, imem_req}, 32'd0);
        instr_ready = 1'b1;
        do_reset();
        step();
        chk("ar_restart_req", {31'b0, imem_req}, 32'd1);
        chk("ar_restart_addr", imem_addr, 32'h0);
        step();
        step();
        chk("ar_restart_pc", instr_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request this cycle.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_rdata  input  32  instruction word, valid the cycle after imem_req.
REQ-008 redirect_valid  input  1  branch/jump redirect from execute.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 instr_valid  output  1  instr/instr_pc/instr_pcplus4 valid toward decode.
REQ-011 instr_ready  input  1  decode accepts this cycle.
REQ-012 instr  output  32  instruction word; bits [31:7] feed the immediate extender.
REQ-013 instr_pc  output  32  address of instr.
REQ-014 instr_pcplus4  output  32  instr_pc + 4, modulo 2^32.

Function
REQ-015 A transfer (pop) occurs when instr_valid and instr_ready are both 1 on a rising edge.
REQ-016 instr_valid, instr and instr_pc are driven from buffer registers only; no combinational path from imem_rdata, instr_ready or redirect_valid.
REQ-017 Without redirect, imem_req = 1 when count + inflight - pop < 2, where count is buffer occupancy and inflight is 1 if a non-discarded request was issued the previous cycle.
REQ-018 Each issued request advances fetch_pc by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 A response is written to the buffer with its pc at the end of the cycle after its request; instr_valid is first 1 two cycles after the request.
REQ-020 Steady state with instr_ready held 1 yields one transfer per cycle.
REQ-021 Buffer is FIFO; simultaneous write and pop at full or empty is legal, and occupancy never exceeds 2.
REQ-022 Redirect cycle: buffer flushed, pending response discarded, imem_req = 1, imem_addr = {redirect_pc[31:2], 2'b00}, fetch_pc <= that address + 4.
REQ-023 A pop coinciding with redirect_valid is void; decode squashes its own capture that cycle.
REQ-024 Redirects on consecutive cycles: each overrides the previous; only the last target's response is buffered.
REQ-025 FSM states: RESET_HOLD (first cycle after rst_n rises, no request), RUN (issue per REQ-017), FULL (count + inflight = 2 and no pop, imem_req = 0). Transitions: RESET_HOLD -> RUN unconditionally; RUN <-> FULL per the credit condition; redirect forces RUN from any state.

Reset
REQ-026 While rst_n = 0: imem_req = 0, instr_valid = 0, count = 0, inflight = 0, fetch_pc = RESET_PC, state = RESET_HOLD, data registers = 0.
REQ-027 Reset assertion mid-operation discards all buffered and in-flight instructions immediately and asynchronously.
REQ-028 First imem_req = 1 with imem_addr = RESET_PC occurs in the second cycle after rst_n deasserts.

Structure
REQ-029 Shared package fetch_pkg holds RESET_PC default, BUF_DEPTH, the FSM state enum and a fetch_entry_t struct {instr[31:0], pc[31:0]}.
REQ-030 The buffer is a sub-module fetch_buffer (2-entry FIFO with push, pop, flush, count); fetch_unit holds the FSM, fetch_pc and inflight/epoch logic.

Verification
REQ-031 Reset release, instr_ready = 1, memory returns addr+0x100 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; instr_valid first high 2 cycles after first request with instr_pc 0x0.
REQ-032 instr_ready = 0 for 5 cycles -> imem_req drops after 2 requests, buffer holds pc 0x0 and 0x4, no instruction lost or duplicated after instr_ready returns to 1.
REQ-033 redirect_valid with redirect_pc = 0x0000_0203 while buffer full -> same-cycle imem_addr 0x200, old entries never appear, next instr_pc 0x200.
REQ-034 Redirects to 0x40 then 0x80 on consecutive cycles -> no instr_pc 0x40 delivered; first delivered instr_pc is 0x80.
REQ-035 Redirect to 0xFFFF_FFFC -> following request addr 0x0000_0000; instr_pcplus4 of first delivered instruction is 0x0.
REQ-036 rst_n asserted with 2 buffered entries -> instr_valid and imem_req 0 in the same cycle; restart from RESET_PC per REQ-028.
